updown_mod_counter: RTL and testbench
=====================================

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 Parameter WIDTH, default 8, count/data/limit width in bits (legal 2..32).
REQ-002 Parameter STEP_W, default 4, step input width in bits (legal 1..WIDTH).
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port load_n, input, 1: synchronous load request, active-low.
REQ-006 Port ce, input, 1: count enable.
REQ-007 Port up_down, input, 1: direction; 1 = up, 0 = down.
REQ-008 Port data_load, input, WIDTH: load value.
REQ-009 Port limit, input, WIDTH: programmable terminal value; count range is 0..limit.
REQ-010 Port step, input, STEP_W: increment/decrement magnitude per enabled cycle.
REQ-011 Port sat_mode, input, 1: 1 = saturate at bounds, 0 = wrap; ignored when the macro in REQ-025 is undefined.
REQ-012 Port clr_ovf, input, 1: clears the sticky overflow flag.
REQ-013 Ports count_out (output, WIDTH) = current count; max_count (output, 1) = count_out==limit; zero (output, 1) = count_out==0.
REQ-014 Ports tc (output, 1) = one-cycle boundary-event pulse; ovf_sticky (output, 1) = sticky boundary-event flag.

Function
REQ-015 Priority per cycle SHALL be: rst_n low > load_n low > ce high > hold.
REQ-016 Load SHALL set count_out to data_load, clamped to limit when data_load > limit; a load SHALL NOT assert tc or set ovf_sticky.
REQ-017 Up with ce: sum = count_out + step in WIDTH+1 bits; if sum <= limit, count_out <= sum; otherwise a boundary event occurs.
REQ-018 Down with ce: if count_out >= step, count_out <= count_out - step; otherwise a boundary event occurs.
REQ-019 Boundary event in wrap mode: up -> count_out <= sum - (limit+1); down -> count_out <= count_out + limit + 1 - step; if step > limit, the result SHALL be 0 instead.
REQ-020 Boundary event in saturate mode: up -> count_out <= limit; down -> count_out <= 0.
REQ-021 step == 0 with ce SHALL hold count_out with no boundary event.
REQ-022 If count_out > limit (limit lowered mid-count) on an enabled cycle, count_out SHALL become 0 (up) or limit (down), and that SHALL be a boundary event.
REQ-023 tc SHALL be registered and high exactly in the cycle following the edge that applied a boundary event, i.e. concurrent with the post-event count_out; a held cycle (ce low or step 0) SHALL drive tc low.
REQ-024 ovf_sticky SHALL set on every boundary event and clear on clr_ovf; on a simultaneous set and clear, the set SHALL win.

Configuration
REQ-025 Macro UPDOWN_MOD_COUNTER_SAT_EN defined: sat_mode selects REQ-020 behaviour when high. Undefined: the saturate logic SHALL be compiled out and every boundary event SHALL wrap per REQ-019; the sat_mode port SHALL remain present but unused.

Reset
REQ-026 While rst_n is low: count_out = 0, tc = 0, ovf_sticky = 0, independent of clk; therefore zero = 1 and max_count = (limit==0).
REQ-027 A reset asserted mid-count SHALL discard any pending load or step; the first enabled edge after release SHALL operate from 0.

Structure
REQ-028 Package updown_mod_counter_pkg SHALL hold the direction constants (DIR_UP = 1, DIR_DOWN = 0), the mode constants (MODE_WRAP = 0, MODE_SAT = 1), and the default WIDTH and STEP_W values.
REQ-029 Sub-module counter_next_calc SHALL be combinational, computing the next count and boundary_event from count_out, step, limit, up_down and mode; the top level SHALL hold the registers, tc and ovf_sticky.
REQ-030 The existing counter_if interface SHALL be extended (limit, step, sat_mode, clr_ovf, tc, ovf_sticky) with DUT, TB and SVA modports.

Verification (WIDTH=8, STEP_W=4)
REQ-031 Reset then limit=9, step=1, up, ce=1 for 10 cycles -> count_out 1..9,0; tc high only when count_out=0; ovf_sticky=1.
REQ-032 limit=9, count_out=8, step=3, up, wrap -> next count_out=1, tc=1; same case with sat_mode=1 and macro defined -> count_out=9, max_count=1.
REQ-033 limit=200, count_out=2, step=5, down, wrap -> count_out=198, tc=1; with saturate -> count_out=0, zero=1.
REQ-034 load_n=0 with ce=1, data_load=250, limit=100 -> count_out=100, tc=0, ovf_sticky unchanged.
REQ-035 ovf_sticky=1 with clr_ovf=1 and a simultaneous boundary event -> ovf_sticky stays 1; next cycle clr_ovf=1, no event -> ovf_sticky=0.
REQ-036 count_out=50, then limit changed to 20, up, ce=1 -> count_out=0, tc=1; rst_n pulsed low mid-cycle -> outputs reset immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/updown_mod_counter_pkg.sv
// Shared constants for the up/down modulo counter.
//   DIR_UP / DIR_DOWN    : encoding of the up_down input
//   MODE_WRAP / MODE_SAT : boundary handling mode fed to counter_next_calc
//   DEFAULT_WIDTH        : default count/data/limit width
//   DEFAULT_STEP_W       : default step input width
package updown_mod_counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam int unsigned DEFAULT_WIDTH  = 8;
    localparam int unsigned DEFAULT_STEP_W = 4;

endpackage : updown_mod_counter_pkg

// File: rtl/counter_if.sv
// Signal bundle for updown_mod_counter with DUT, TB and SVA views.
//   clk        : counter clock (interface port)
//   rst_n      : asynchronous active-low reset
//   load_n     : synchronous active-low load request
//   ce         : count enable
//   up_down    : direction (DIR_UP / DIR_DOWN)
//   data_load  : load value
//   limit      : terminal value, count range 0..limit
//   step       : magnitude per enabled cycle
//   sat_mode   : saturate (1) or wrap (0) at bounds
//   clr_ovf    : clears the sticky overflow flag
//   count_out  : current count
//   max_count  : count_out == limit
//   zero       : count_out == 0
//   tc         : one-cycle boundary-event pulse
//   ovf_sticky : sticky boundary-event flag
interface counter_if
    import updown_mod_counter_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STEP_W = DEFAULT_STEP_W
) (
    input logic clk
);

    logic              rst_n;
    logic              load_n;
    logic              ce;
    logic              up_down;
    logic [WIDTH-1:0]  data_load;
    logic [WIDTH-1:0]  limit;
    logic [STEP_W-1:0] step;
    logic              sat_mode;
    logic              clr_ovf;
    logic [WIDTH-1:0]  count_out;
    logic              max_count;
    logic              zero;
    logic              tc;
    logic              ovf_sticky;

    // Design-side view.
    modport dut (
        input  clk, rst_n, load_n, ce, up_down, data_load, limit, step,
               sat_mode, clr_ovf,
        output count_out, max_count, zero, tc, ovf_sticky
    );

    // Stimulus-side view.
    modport tb (
        input  clk, count_out, max_count, zero, tc, ovf_sticky,
        output rst_n, load_n, ce, up_down, data_load, limit, step,
               sat_mode, clr_ovf
    );

    // Passive observer view for assertion binding.
    modport sva (
        input  clk, rst_n, load_n, ce, up_down, data_load, limit, step,
               sat_mode, clr_ovf, count_out, max_count, zero, tc, ovf_sticky
    );

endinterface : counter_if

// File: rtl/counter_next_calc.sv
// Combinational next-count and boundary-event calculation for one enabled
// counting cycle. Load and hold are handled by the caller.
// Saturate handling exists only when UPDOWN_MOD_COUNTER_SAT_EN is defined;
// otherwise every boundary event wraps and mode is unused.
//   count          : current count
//   step           : magnitude per enabled cycle
//   limit          : terminal value
//   up_down        : direction (DIR_UP / DIR_DOWN)
//   mode           : MODE_WRAP / MODE_SAT
//   next_count     : count to register on an enabled cycle
//   boundary_event : the enabled cycle crossed or was outside 0..limit
module counter_next_calc
    import updown_mod_counter_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STEP_W = DEFAULT_STEP_W
) (
    input  logic [WIDTH-1:0]  count,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic              up_down,
    input  logic              mode,
    output logic [WIDTH-1:0]  next_count,
    output logic              boundary_event
);

    // One guard bit keeps count+step and count+limit+1 from overflowing.
    localparam int unsigned EW = WIDTH + 1;

    logic [EW-1:0]    count_e;
    logic [EW-1:0]    limit_e;
    logic [EW-1:0]    step_e;
    logic [EW-1:0]    sum_e;
    logic [EW-1:0]    wrap_up_e;
    logic [EW-1:0]    wrap_dn_e;
    logic             step_zero;
    logic             out_of_range;
    logic             step_gt_limit;
    logic [WIDTH-1:0] wrap_next;
    logic [WIDTH-1:0] bound_next;

    assign count_e       = {1'b0, count};
    assign limit_e       = {1'b0, limit};
    assign step_e        = EW'(step);
    assign sum_e         = count_e + step_e;
    assign wrap_up_e     = sum_e - limit_e - EW'(1);
    assign wrap_dn_e     = count_e + limit_e + EW'(1) - step_e;
    assign step_zero     = (step == '0);
    assign out_of_range  = (count_e > limit_e);
    assign step_gt_limit = (step_e > limit_e);

    // Wrapped result; a step larger than the whole range lands on 0.
    always_comb begin
        wrap_next = '0;
        if (!step_gt_limit) begin
            wrap_next = (up_down == DIR_UP) ? WIDTH'(wrap_up_e) : WIDTH'(wrap_dn_e);
        end
    end

`ifdef UPDOWN_MOD_COUNTER_SAT_EN
    // Saturate pins to the bound in the direction of travel.
    always_comb begin
        bound_next = wrap_next;
        if (mode == MODE_SAT) begin
            bound_next = (up_down == DIR_UP) ? limit : '0;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign bound_next  = wrap_next;
`endif

    // Step 0 is a hold; an out-of-range count is pulled back in before any step.
    always_comb begin
        next_count     = count;
        boundary_event = 1'b0;
        if (!step_zero) begin
            if (out_of_range) begin
                boundary_event = 1'b1;
                next_count     = (up_down == DIR_UP) ? '0 : limit;
            end else if (up_down == DIR_UP) begin
                if (sum_e <= limit_e) begin
                    next_count = WIDTH'(sum_e);
                end else begin
                    boundary_event = 1'b1;
                    next_count     = bound_next;
                end
            end else begin
                if (count_e >= step_e) begin
                    next_count = WIDTH'(count_e - step_e);
                end else begin
                    boundary_event = 1'b1;
                    next_count     = bound_next;
                end
            end
        end
    end

endmodule : counter_next_calc

// File: rtl/updown_mod_counter.sv
// Programmable-limit up/down counter with variable step, load, terminal
// pulse and sticky overflow. Optional saturate mode via the macro
// UPDOWN_MOD_COUNTER_SAT_EN; without it sat_mode is present but unused.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_n     : synchronous load (active-low), beats counting
//   ce         : count enable
//   up_down    : 1 = up, 0 = down
//   data_load  : load value, clamped to limit
//   limit      : terminal value, count range 0..limit
//   step       : magnitude per enabled cycle
//   sat_mode   : 1 = saturate, 0 = wrap
//   clr_ovf    : clears ovf_sticky (a same-cycle event wins)
//   count_out  : current count
//   max_count  : count_out == limit
//   zero       : count_out == 0
//   tc         : registered boundary-event pulse
//   ovf_sticky : sticky boundary-event flag
module updown_mod_counter
    import updown_mod_counter_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STEP_W = DEFAULT_STEP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_n,
    input  logic              ce,
    input  logic              up_down,
    input  logic [WIDTH-1:0]  data_load,
    input  logic [WIDTH-1:0]  limit,
    input  logic [STEP_W-1:0] step,
    input  logic              sat_mode,
    input  logic              clr_ovf,
    output logic [WIDTH-1:0]  count_out,
    output logic              max_count,
    output logic              zero,
    output logic              tc,
    output logic              ovf_sticky
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] load_value;
    logic             boundary_event;
    logic             event_applied;
    logic             mode;
    logic             tc_q;
    logic             ovf_q;

`ifdef UPDOWN_MOD_COUNTER_SAT_EN
    assign mode = sat_mode ? MODE_SAT : MODE_WRAP;
`else
    logic unused_sat_mode;
    assign unused_sat_mode = sat_mode;
    assign mode            = MODE_WRAP;
`endif

    // Loads never exceed the current terminal value.
    assign load_value = (data_load > limit) ? limit : data_load;

    counter_next_calc #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_next_calc (
        .count          (count_q),
        .step           (step),
        .limit          (limit),
        .up_down        (up_down),
        .mode           (mode),
        .next_count     (next_count),
        .boundary_event (boundary_event)
    );

    // Events only count on enabled, non-load cycles.
    assign event_applied = load_n & ce & boundary_event;

    // Count register: load beats enable beats hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (!load_n) begin
            count_q <= load_value;
        end else if (ce) begin
            count_q <= next_count;
        end
    end

    // Terminal pulse and sticky flag; a set beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            tc_q  <= event_applied;
            ovf_q <= event_applied | (ovf_q & ~clr_ovf);
        end
    end

    assign count_out  = count_q;
    assign tc         = tc_q;
    assign ovf_sticky = ovf_q;
    assign max_count  = (count_q == limit);
    assign zero       = (count_q == '0);

endmodule : updown_mod_counter

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter (WIDTH=8, STEP_W=4): directed
// scenarios followed by random traffic against an arithmetic reference model.
module tb_updown_mod_counter;

    logic clk;
    counter_if #(.WIDTH(8), .STEP_W(4)) cif (.clk(clk));

    updown_mod_counter #(.WIDTH(8), .STEP_W(4)) dut (
        .clk        (clk),
        .rst_n      (cif.rst_n),
        .load_n     (cif.load_n),
        .ce         (cif.ce),
        .up_down    (cif.up_down),
        .data_load  (cif.data_load),
        .limit      (cif.limit),
        .step       (cif.step),
        .sat_mode   (cif.sat_mode),
        .clr_ovf    (cif.clr_ovf),
        .count_out  (cif.count_out),
        .max_count  (cif.max_count),
        .zero       (cif.zero),
        .tc         (cif.tc),
        .ovf_sticky (cif.ovf_sticky)
    );

    typedef struct packed {
        logic [7:0] cnt;
        logic       tc;
        logic       ovf;
        logic       maxc;
        logic       zero;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_cnt    = 0;
    bit   m_ovf    = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: apply one clock's worth of the counting rules to m_cnt/m_ovf.
    task automatic model(input bit ld_n, input bit c, input bit ud, input int dl,
                         input int lim, input int st, input bit sm, input bit clr,
                         output bit ev);
        bit sat;
        int s;
`ifdef UPDOWN_MOD_COUNTER_SAT_EN
        sat = sm;
`else
        sat = 1'b0;
        if (sm) sat = 1'b0;
`endif
        ev = 1'b0;
        if (!ld_n) begin
            m_cnt = (dl > lim) ? lim : dl;
        end else if (c && st != 0) begin
            if (m_cnt > lim) begin
                ev = 1'b1;
                m_cnt = ud ? 0 : lim;
            end else if (ud) begin
                s = m_cnt + st;
                if (s <= lim) m_cnt = s;
                else begin
                    ev = 1'b1;
                    m_cnt = sat ? lim : ((st > lim) ? 0 : s - (lim + 1));
                end
            end else begin
                if (m_cnt >= st) m_cnt = m_cnt - st;
                else begin
                    ev = 1'b1;
                    m_cnt = sat ? 0 : ((st > lim) ? 0 : m_cnt + lim + 1 - st);
                end
            end
        end
        m_ovf = ev | (m_ovf & !clr);
    endtask

    // Drive one cycle of inputs at the falling edge and queue the expectation.
    task automatic drive(input bit ld_n, input bit c, input bit ud, input int dl,
                         input int lim, input int st, input bit sm, input bit clr);
        bit   ev;
        exp_t e;
        @(negedge clk);
        cif.load_n    = ld_n;
        cif.ce        = c;
        cif.up_down   = ud;
        cif.data_load = 8'(dl);
        cif.limit     = 8'(lim);
        cif.step      = 4'(st);
        cif.sat_mode  = sm;
        cif.clr_ovf   = clr;
        model(ld_n, c, ud, dl, lim, st, sm, clr, ev);
        e.cnt  = 8'(m_cnt);
        e.tc   = ev;
        e.ovf  = m_ovf;
        e.maxc = (m_cnt == lim);
        e.zero = (m_cnt == 0);
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every cycle presents an output; compare against the queue head.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_count", int'(cif.count_out), int'(e.cnt));
            check("sb_tc", int'(cif.tc), int'(e.tc));
            check("sb_ovf", int'(cif.ovf_sticky), int'(e.ovf));
            check("sb_max", int'(cif.max_count), int'(e.maxc));
            check("sb_zero", int'(cif.zero), int'(e.zero));
        end
    end

    initial begin
        int lim;
        bit prior_ovf;

        cif.rst_n     = 1'b0;
        cif.load_n    = 1'b1;
        cif.ce        = 1'b0;
        cif.up_down   = 1'b1;
        cif.data_load = 8'd0;
        cif.limit     = 8'd0;
        cif.step      = 4'd0;
        cif.sat_mode  = 1'b0;
        cif.clr_ovf   = 1'b0;
        #2;
        check("rst_count", int'(cif.count_out), 0);
        check("rst_tc", int'(cif.tc), 0);
        check("rst_ovf", int'(cif.ovf_sticky), 0);
        check("rst_zero", int'(cif.zero), 1);
        check("rst_max_lim0", int'(cif.max_count), 1);
        cif.limit = 8'd9;
        #1;
        check("rst_max_lim9", int'(cif.max_count), 0);
        @(negedge clk);
        cif.rst_n = 1'b1;

        // Count 1..9 then wrap to 0.
        repeat (10) drive(1, 1, 1, 0, 9, 1, 0, 0);
        settle();
        check("up9_wrap_count", int'(cif.count_out), 0);
        check("up9_wrap_tc", int'(cif.tc), 1);
        check("up9_wrap_ovf", int'(cif.ovf_sticky), 1);

        // Up wrap with step 3 from 8, limit 9.
        drive(0, 0, 1, 8, 9, 3, 0, 0);
        drive(1, 1, 1, 0, 9, 3, 0, 0);
        settle();
        check("up_wrap_count", int'(cif.count_out), 1);
        check("up_wrap_tc", int'(cif.tc), 1);
`ifdef UPDOWN_MOD_COUNTER_SAT_EN
        drive(0, 0, 1, 8, 9, 3, 1, 0);
        drive(1, 1, 1, 0, 9, 3, 1, 0);
        settle();
        check("up_sat_count", int'(cif.count_out), 9);
        check("up_sat_max", int'(cif.max_count), 1);
`endif

        // Down wrap with step 5 from 2, limit 200.
        drive(0, 0, 0, 2, 200, 5, 0, 0);
        drive(1, 1, 0, 0, 200, 5, 0, 0);
        settle();
        check("dn_wrap_count", int'(cif.count_out), 198);
        check("dn_wrap_tc", int'(cif.tc), 1);
`ifdef UPDOWN_MOD_COUNTER_SAT_EN
        drive(0, 0, 0, 2, 200, 5, 1, 0);
        drive(1, 1, 0, 0, 200, 5, 1, 0);
        settle();
        check("dn_sat_count", int'(cif.count_out), 0);
        check("dn_sat_zero", int'(cif.zero), 1);
`endif

        // Load beats enable, clamps, and leaves tc/ovf alone.
        prior_ovf = m_ovf;
        drive(0, 1, 1, 250, 100, 7, 0, 0);
        settle();
        check("load_clamp_count", int'(cif.count_out), 100);
        check("load_clamp_tc", int'(cif.tc), 0);
        check("load_clamp_ovf", int'(cif.ovf_sticky), int'(prior_ovf));

        // Set wins over clear, then clear alone.
        drive(0, 0, 1, 9, 9, 1, 0, 0);
        drive(1, 1, 1, 0, 9, 1, 0, 1);
        settle();
        check("ovf_set_wins", int'(cif.ovf_sticky), 1);
        drive(1, 0, 1, 0, 9, 1, 0, 1);
        settle();
        check("ovf_cleared", int'(cif.ovf_sticky), 0);

        // Limit lowered below the count.
        drive(0, 0, 1, 50, 100, 1, 0, 0);
        drive(1, 1, 1, 0, 20, 1, 0, 0);
        settle();
        check("lim_drop_count", int'(cif.count_out), 0);
        check("lim_drop_tc", int'(cif.tc), 1);
        drive(1, 1, 1, 0, 20, 3, 0, 0);
        drive(1, 1, 1, 0, 20, 3, 0, 0);

        // Asynchronous reset mid-cycle; pending load discarded.
        @(posedge clk);
        #3;
        cif.rst_n     = 1'b0;
        cif.load_n    = 1'b0;
        cif.data_load = 8'd77;
        cif.ce        = 1'b1;
        m_cnt = 0;
        m_ovf = 1'b0;
        #1;
        check("async_rst_count", int'(cif.count_out), 0);
        check("async_rst_tc", int'(cif.tc), 0);
        check("async_rst_ovf", int'(cif.ovf_sticky), 0);
        check("async_rst_zero", int'(cif.zero), 1);
        @(posedge clk);
        #1;
        check("rst_hold_count", int'(cif.count_out), 0);
        @(negedge clk);
        cif.rst_n  = 1'b1;
        cif.load_n = 1'b1;
        cif.ce     = 1'b0;
        drive(1, 1, 1, 0, 20, 2, 0, 0);
        settle();
        check("post_rst_count", int'(cif.count_out), 2);

        // Random traffic.
        lim = 37;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                lim = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15))
                                                  : int'($urandom_range(0, 255));
            end
            drive($urandom_range(0, 11) != 0, $urandom_range(0, 4) != 0,
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), lim,
                  int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0);
        end

        // Drain the scoreboard within a bounded number of cycles.
        repeat (4) @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_updown_mod_counter
